// File: rtl/soc_int_mnt_pkg.sv
// Shared types and constants for the soc_int_mnt end-of-test / console monitor.
package soc_int_mnt_pkg;

  // Reason the test ended; FC_NONE also covers a passing test.
  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_MAGIC   = 2'd1,
    FC_WDOG    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_cause_e;

  // Default magic values, console address and timing windows.
  localparam logic [63:0] PASS_MAGIC_DEF     = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FAIL_MAGIC_DEF     = 64'h0000_0023_8234_8720;
  localparam logic [31:0] CONSOLE_ADDR_DEF   = 32'h01FF_FFF0;
  localparam int unsigned WDOG_PERIOD_DEF    = 50000;
  localparam logic [31:0] MAX_RUN_CYCLES_DEF = 32'h0300_0000;

  // Word-aligned 32-bit lanes of the 128-bit write bus; the console byte
  // is the low byte of whichever lane is fully strobed.
  localparam logic [15:0] STRB_LANE0 = 16'h000F;
  localparam logic [15:0] STRB_LANE1 = 16'h00F0;
  localparam logic [15:0] STRB_LANE2 = 16'h0F00;
  localparam logic [15:0] STRB_LANE3 = 16'hF000;

  typedef struct packed {
    logic       vld;
    logic [7:0] ch;
  } con_byte_t;

  // Pick the console character out of a write beat; any strobe pattern
  // other than a single full lane yields no character.
  function automatic con_byte_t console_byte(input logic [15:0]  strb,
                                             input logic [127:0] wdata);
    con_byte_t r;
    r.vld = 1'b1;
    r.ch  = 8'h00;
    case (strb)
      STRB_LANE0: r.ch = wdata[7:0];
      STRB_LANE1: r.ch = wdata[39:32];
      STRB_LANE2: r.ch = wdata[71:64];
      STRB_LANE3: r.ch = wdata[103:96];
      default:    r.vld = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/soc_int_mnt_wdog.sv
// Retirement watchdog: flags a hang when a whole window of WDOG_PERIOD
// cycles passes without any retirement.
module soc_int_mnt_wdog
  import soc_int_mnt_pkg::*;
#(
  parameter int unsigned WDOG_PERIOD = WDOG_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] retire_vld,
  output logic       hang_o
);

  // win_q tracks cycle_cnt modulo WDOG_PERIOD without a divider.
  localparam logic [31:0] WIN_LAST = 32'(WDOG_PERIOD - 1);
  localparam logic [31:0] WIN_RST  = (WDOG_PERIOD == 1) ? 32'd0 : 32'd1;

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] win_q, win_d;
  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        win_hit;

  assign win_hit = (win_q == 32'd0);
  assign hang_o  = win_hit && (wdog_cnt_q == 32'd0);

  // Next-state: window position restarts on period end and on the 2^32
  // wrap (0 is a multiple of every period); retirements in the window
  // boundary cycle are dropped.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    if ((cycle_cnt_q == 32'hFFFF_FFFF) || (win_q == WIN_LAST)) begin
      win_d = 32'd0;
    end else begin
      win_d = win_q + 32'd1;
    end
    if (win_hit) begin
      wdog_cnt_d = 32'd0;
    end else if (|retire_vld) begin
      wdog_cnt_d = wdog_cnt_q + 32'd1;
    end else begin
      wdog_cnt_d = wdog_cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'd1;
      win_q       <= WIN_RST;
      wdog_cnt_q  <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      win_q       <= win_d;
      wdog_cnt_q  <= wdog_cnt_d;
    end
  end

endmodule

// File: rtl/soc_int_mnt.sv
// End-of-test and console monitor: watches writeback buses for magic
// values, the AXI slave write channel for console bytes, and runs a
// retirement watchdog plus a global run timeout.
module soc_int_mnt
  import soc_int_mnt_pkg::*;
#(
  parameter logic [63:0] PASS_MAGIC     = PASS_MAGIC_DEF,
  parameter logic [63:0] FAIL_MAGIC     = FAIL_MAGIC_DEF,
  parameter logic [31:0] CONSOLE_ADDR   = CONSOLE_ADDR_DEF,
  parameter int unsigned WDOG_PERIOD    = WDOG_PERIOD_DEF,
  parameter logic [31:0] MAX_RUN_CYCLES = MAX_RUN_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   retire_vld,
  input  logic [63:0]  wb_data0,
  input  logic [63:0]  wb_data1,
  input  logic [63:0]  wb_data2,
  input  logic [3:0]   axi_awlen,
  input  logic [31:0]  axi_addr,
  input  logic         axi_wvalid,
  input  logic [15:0]  axi_wstrb,
  input  logic [127:0] axi_wdata,
  input  logic         axi_clk_en,
  output logic         con_vld,
  output logic [7:0]   con_char,
  output logic         test_done,
  output logic         test_pass,
  output logic [1:0]   fail_cause
);

  logic [63:0] wb0_q, wb1_q, wb2_q;
  logic [3:0]  awlen_q;
  logic [31:0] addr_q;
  logic        wvalid_q;
  logic [15:0] wstrb_q;

  logic [31:0] run_cnt_q, run_cnt_d;
  logic        done_q, pass_q;
  fail_cause_e cause_q;
  logic        con_vld_q;
  logic [7:0]  con_char_q;

  logic        hang;
  logic        pass_hit, fail_hit, timeout_hit, con_hit;
  con_byte_t   con_sel;

  soc_int_mnt_wdog #(
    .WDOG_PERIOD (WDOG_PERIOD)
  ) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .retire_vld (retire_vld),
    .hang_o     (hang)
  );

  // Stage 1: capture the observed buses so compares run off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb0_q    <= '0;
      wb1_q    <= '0;
      wb2_q    <= '0;
      awlen_q  <= '0;
      addr_q   <= '0;
      wvalid_q <= 1'b0;
      wstrb_q  <= '0;
    end else begin
      wb0_q    <= wb_data0;
      wb1_q    <= wb_data1;
      wb2_q    <= wb_data2;
      awlen_q  <= axi_awlen;
      addr_q   <= axi_addr;
      wvalid_q <= axi_wvalid;
      wstrb_q  <= axi_wstrb;
    end
  end

  // Stage 2 event detection; wdata and clk_en line up with the delayed
  // address phase, so they are used directly.
  always_comb begin
    pass_hit    = (wb0_q == PASS_MAGIC) || (wb1_q == PASS_MAGIC) || (wb2_q == PASS_MAGIC);
    fail_hit    = (wb0_q == FAIL_MAGIC) || (wb1_q == FAIL_MAGIC) || (wb2_q == FAIL_MAGIC);
    run_cnt_d   = run_cnt_q + 32'd1;
    timeout_hit = (run_cnt_d > MAX_RUN_CYCLES);
    con_sel     = console_byte(wstrb_q, axi_wdata);
    con_hit     = con_sel.vld && (awlen_q == 4'd0) && (addr_q == CONSOLE_ADDR)
                  && wvalid_q && axi_clk_en;
  end

  // Sticky status with priority pass > fail > watchdog > timeout; a
  // console byte only goes out in a cycle with no end-of-test event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_q  <= 32'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cause_q    <= FC_NONE;
      con_vld_q  <= 1'b0;
      con_char_q <= 8'h00;
    end else begin
      run_cnt_q <= run_cnt_d;
      con_vld_q <= 1'b0;
      if (!done_q) begin
        if (pass_hit) begin
          done_q  <= 1'b1;
          pass_q  <= 1'b1;
          cause_q <= FC_NONE;
        end else if (fail_hit) begin
          done_q  <= 1'b1;
          pass_q  <= 1'b0;
          cause_q <= FC_MAGIC;
        end else if (hang) begin
          done_q  <= 1'b1;
          pass_q  <= 1'b0;
          cause_q <= FC_WDOG;
        end else if (timeout_hit) begin
          done_q  <= 1'b1;
          pass_q  <= 1'b0;
          cause_q <= FC_TIMEOUT;
        end else if (con_hit) begin
          con_vld_q  <= 1'b1;
          con_char_q <= con_sel.ch;
        end
      end
    end
  end

  assign con_vld    = con_vld_q;
  assign con_char   = con_char_q;
  assign test_done  = done_q;
  assign test_pass  = pass_q;
  assign fail_cause = cause_q;

endmodule

// File: tb/tb_soc_int_mnt.sv
// Directed self-checking bench for soc_int_mnt (short watchdog and
// timeout windows so every scenario fits in a few hundred cycles).
module tb_soc_int_mnt;

  localparam logic [63:0] PASS_V  = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FAIL_V  = 64'h0000_0023_8234_8720;
  localparam logic [31:0] CON_A   = 32'h01FF_FFF0;
  localparam logic [127:0] NOISE  = 128'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_9696_6969;

  logic         clk;
  logic         rst;
  logic [2:0]   retire_vld;
  logic [63:0]  wb_data0, wb_data1, wb_data2;
  logic [3:0]   axi_awlen;
  logic [31:0]  axi_addr;
  logic         axi_wvalid;
  logic [15:0]  axi_wstrb;
  logic [127:0] axi_wdata;
  logic         axi_clk_en;
  logic         con_vld;
  logic [7:0]   con_char;
  logic         test_done;
  logic         test_pass;
  logic [1:0]   fail_cause;

  int errors = 0;
  int checks = 0;

  soc_int_mnt #(
    .WDOG_PERIOD    (100),
    .MAX_RUN_CYCLES (32'd200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .retire_vld (retire_vld),
    .wb_data0   (wb_data0),
    .wb_data1   (wb_data1),
    .wb_data2   (wb_data2),
    .axi_awlen  (axi_awlen),
    .axi_addr   (axi_addr),
    .axi_wvalid (axi_wvalid),
    .axi_wstrb  (axi_wstrb),
    .axi_wdata  (axi_wdata),
    .axi_clk_en (axi_clk_en),
    .con_vld    (con_vld),
    .con_char   (con_char),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .fail_cause (fail_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    retire_vld = 3'b000;
    wb_data0   = '0;
    wb_data1   = '0;
    wb_data2   = '0;
    axi_awlen  = '0;
    axi_addr   = '0;
    axi_wvalid = 1'b0;
    axi_wstrb  = '0;
    axi_wdata  = '0;
    axi_clk_en = 1'b0;
  endtask

  // Reset, then release 1 time unit after an edge: the next edge is edge 1.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One console write beat; returns con_vld after capture, after the
  // output edge and one edge later, plus the character seen.
  task automatic console_xfer(input logic [31:0] addr, input logic [3:0] len,
                              input logic [15:0] strb, input logic en,
                              input logic [127:0] data,
                              output logic v0, output logic v1,
                              output logic [7:0] ch, output logic v2);
    axi_addr = addr; axi_awlen = len; axi_wstrb = strb; axi_wvalid = 1'b1;
    axi_wdata = data; axi_clk_en = en;
    tick(1);
    axi_addr = '0; axi_awlen = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
    v0 = con_vld;
    tick(1);
    v1 = con_vld;
    ch = con_char;
    tick(1);
    v2 = con_vld;
    axi_wdata = '0; axi_clk_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if ({con_vld, con_char, test_done, test_pass, fail_cause} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b ch=%h done=%b pass=%b cause=%0d, want all 0",
               con_vld, con_char, test_done, test_pass, fail_cause);
    end
    @(posedge clk); #1; rst = 1'b0;
    tick(1);
    checks++;
    if ({con_vld, test_done, test_pass, fail_cause} !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: got vld=%b done=%b pass=%b cause=%0d, want all 0",
               con_vld, test_done, test_pass, fail_cause);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_pass_magic();
    logic v0, v1, v2;
    logic [7:0] ch;
    do_reset();
    retire_vld = 3'b001;
    tick(2);
    wb_data1 = PASS_V;
    tick(1);
    wb_data1 = '0;
    checks++;
    if (test_done !== 1'b0) begin
      errors++;
      $display("FAIL pass_latency_early: done=%b want 0", test_done);
    end
    tick(1);
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1100) begin
      errors++;
      $display("FAIL pass_magic: done=%b pass=%b cause=%0d want 1 1 0", test_done, test_pass, fail_cause);
    end
    wb_data2 = FAIL_V;
    tick(3);
    wb_data2 = '0;
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1100) begin
      errors++;
      $display("FAIL pass_frozen: done=%b pass=%b cause=%0d want 1 1 0", test_done, test_pass, fail_cause);
    end
    console_xfer(CON_A, 4'd0, 16'h000F, 1'b1, NOISE, v0, v1, ch, v2);
    checks++;
    if ({v0, v1, v2} !== 3'b000) begin
      errors++;
      $display("FAIL console_after_done: vld=%b%b%b want 000", v0, v1, v2);
    end
    $display("pass_magic: done=%b pass=%b cause=%0d", test_done, test_pass, fail_cause);
  endtask

  task automatic test_fail_magic();
    do_reset();
    retire_vld = 3'b010;
    wb_data2 = FAIL_V;
    tick(1);
    wb_data2 = '0;
    tick(1);
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1001) begin
      errors++;
      $display("FAIL fail_magic: done=%b pass=%b cause=%0d want 1 0 1", test_done, test_pass, fail_cause);
    end
    $display("fail_magic: done=%b pass=%b cause=%0d", test_done, test_pass, fail_cause);
    do_reset();
    retire_vld = 3'b010;
    wb_data0 = PASS_V;
    wb_data2 = FAIL_V;
    tick(1);
    wb_data0 = '0;
    wb_data2 = '0;
    tick(1);
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1100) begin
      errors++;
      $display("FAIL pass_over_fail: done=%b pass=%b cause=%0d want 1 1 0", test_done, test_pass, fail_cause);
    end
    $display("pass_over_fail: done=%b pass=%b cause=%0d", test_done, test_pass, fail_cause);
  endtask

  task automatic test_console();
    logic [15:0] strbs [4];
    logic [7:0]  chars [4];
    int          ofs   [4];
    logic [127:0] data;
    logic v0, v1, v2;
    logic [7:0] ch;
    strbs = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    chars = '{8'h48, 8'h41, 8'h7A, 8'h0A};
    ofs   = '{0, 32, 64, 96};
    do_reset();
    retire_vld = 3'b100;
    for (int i = 0; i < 4; i++) begin
      data = NOISE;
      data[ofs[i] +: 8] = chars[i];
      console_xfer(CON_A, 4'd0, strbs[i], 1'b1, data, v0, v1, ch, v2);
      checks++;
      if ({v0, v1, v2} !== 3'b010 || ch !== chars[i]) begin
        errors++;
        $display("FAIL console_lane%0d: vld=%b%b%b ch=%h want 010 ch=%h", i, v0, v1, v2, ch, chars[i]);
      end
      $display("console lane%0d: strb=%h ch=%h vld=%b", i, strbs[i], ch, v1);
    end
    data = NOISE;
    data[39:32] = 8'h41;
    console_xfer(CON_A, 4'd0, 16'h0003, 1'b1, data, v0, v1, ch, v2);
    checks++;
    if ({v0, v1, v2} !== 3'b000) begin
      errors++;
      $display("FAIL console_bad_strb: vld=%b%b%b want 000", v0, v1, v2);
    end
    console_xfer(32'h01FF_FFF4, 4'd0, 16'h00F0, 1'b1, data, v0, v1, ch, v2);
    checks++;
    if ({v0, v1, v2} !== 3'b000) begin
      errors++;
      $display("FAIL console_bad_addr: vld=%b%b%b want 000", v0, v1, v2);
    end
    console_xfer(CON_A, 4'd1, 16'h00F0, 1'b1, data, v0, v1, ch, v2);
    checks++;
    if ({v0, v1, v2} !== 3'b000) begin
      errors++;
      $display("FAIL console_burst: vld=%b%b%b want 000", v0, v1, v2);
    end
    console_xfer(CON_A, 4'd0, 16'h00F0, 1'b0, data, v0, v1, ch, v2);
    checks++;
    if ({v0, v1, v2} !== 3'b000) begin
      errors++;
      $display("FAIL console_clk_en: vld=%b%b%b want 000", v0, v1, v2);
    end
    wb_data0 = PASS_V;
    console_xfer(CON_A, 4'd0, 16'h00F0, 1'b1, data, v0, v1, ch, v2);
    wb_data0 = '0;
    checks++;
    if ({v0, v1, v2} !== 3'b000 || test_done !== 1'b1) begin
      errors++;
      $display("FAIL console_vs_magic: vld=%b%b%b done=%b want 000 done=1", v0, v1, v2, test_done);
    end
    $display("console negatives: checked, done=%b", test_done);
  endtask

  task automatic test_watchdog();
    do_reset();
    tick(99);
    checks++;
    if (test_done !== 1'b0) begin
      errors++;
      $display("FAIL wdog_early: done=%b want 0", test_done);
    end
    tick(1);
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1010) begin
      errors++;
      $display("FAIL wdog_fire: done=%b pass=%b cause=%0d want 1 0 2", test_done, test_pass, fail_cause);
    end
    $display("wdog idle: done=%b cause=%0d", test_done, fail_cause);
    // One retire in window 1; the only retire of window 2 lands in the
    // boundary cycle (cycle_cnt==100) and must not count.
    do_reset();
    tick(9);
    retire_vld = 3'b001;
    tick(1);
    retire_vld = 3'b000;
    tick(89);
    retire_vld = 3'b001;
    tick(1);
    retire_vld = 3'b000;
    checks++;
    if (test_done !== 1'b0) begin
      errors++;
      $display("FAIL wdog_window1_ok: done=%b want 0", test_done);
    end
    tick(99);
    checks++;
    if (test_done !== 1'b0) begin
      errors++;
      $display("FAIL wdog_window2_early: done=%b want 0", test_done);
    end
    tick(1);
    checks++;
    if ({test_done, fail_cause} !== 3'b110) begin
      errors++;
      $display("FAIL wdog_boundary_retire: done=%b cause=%0d want 1 2", test_done, fail_cause);
    end
    $display("wdog boundary: done=%b cause=%0d", test_done, fail_cause);
  endtask

  task automatic test_timeout();
    do_reset();
    retire_vld = 3'b111;
    tick(200);
    checks++;
    if (test_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: done=%b want 0", test_done);
    end
    tick(1);
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1011) begin
      errors++;
      $display("FAIL timeout_fire: done=%b pass=%b cause=%0d want 1 0 3", test_done, test_pass, fail_cause);
    end
    wb_data1 = PASS_V;
    tick(3);
    wb_data1 = '0;
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1011) begin
      errors++;
      $display("FAIL timeout_frozen: done=%b pass=%b cause=%0d want 1 0 3", test_done, test_pass, fail_cause);
    end
    $display("timeout: done=%b cause=%0d", test_done, fail_cause);
  endtask

  task automatic test_reset_midtest();
    do_reset();
    retire_vld = 3'b001;
    wb_data2 = FAIL_V;
    tick(1);
    wb_data2 = '0;
    tick(1);
    rst = 1'b1;
    #2;
    checks++;
    if ({con_vld, test_done, test_pass, fail_cause} !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: vld=%b done=%b pass=%b cause=%0d want all 0",
               con_vld, test_done, test_pass, fail_cause);
    end
    @(posedge clk); #1; rst = 1'b0;
    retire_vld = 3'b001;
    wb_data0 = PASS_V;
    tick(1);
    wb_data0 = '0;
    tick(1);
    checks++;
    if ({test_done, test_pass, fail_cause} !== 4'b1100) begin
      errors++;
      $display("FAIL pass_after_reset: done=%b pass=%b cause=%0d want 1 1 0", test_done, test_pass, fail_cause);
    end
    $display("reset midtest: done=%b pass=%b", test_done, test_pass);
  endtask

  initial begin
    test_reset();
    test_pass_magic();
    test_fail_magic();
    test_console();
    test_watchdog();
    test_timeout();
    test_reset_midtest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
